univ_shift_counter: RTL
=======================

UNIV_SHIFT_COUNTER -- requirements
Module: univ_shift_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width; legal range 2..32.
REQ-002 SHALL provide parameter SAT, default 0, count mode: 0 = modulo wrap, 1 = saturating.
REQ-003 SHALL provide local width SW = clog2(WIDTH), shift-amount width.
REQ-004 SHALL provide one clock and a synchronous active-high reset: clk and rst, with no other clock or reset.
REQ-005 SHALL provide the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cl  in  1  clear
- ld  in  1  parallel load
- inc  in  1  increment
- dec  in  1  decrement
- sr  in  1  shift right
- sl  in  1  shift left
- in  in  WIDTH  parallel load data
- ir  in  1  serial input for right shift
- il  in  1  serial input for left shift
- smode  in  2  shift mode: 00 serial, 01 rotate, 10 arithmetic, 11 = serial
- shamt  in  SW  shift amount
- out  out  WIDTH  register contents
- carry  out  1  carry/borrow/shifted-out flag
- zero  out  1  out == 0 (combinational)
- busy  out  1  multi-bit shift in progress
- done  out  1  one-cycle shift-complete pulse

Function
REQ-006 SHALL use command priority cl > ld > inc > dec > sr > sl; at most one command acts per edge; no command = hold.
REQ-007 SHALL, on cl, set out=0 and carry=0; cl acts even while busy, aborting any shift: busy=0, remaining count=0, no done pulse.
REQ-008 SHALL, on ld, set out=in and carry=0.
REQ-009 SHALL, on inc with SAT=0, set out=out+1 mod 2^WIDTH; carry=1 iff old out was all-ones, else 0.
REQ-010 SHALL, on inc with SAT=1, hold out at all-ones and set carry=1 when old out is all-ones; otherwise add 1 and set carry=0.
REQ-011 SHALL, on dec, mirror REQ-009/010: wrap to all-ones, or with SAT=1 hold at 0; carry=1 iff old out was 0.
REQ-012 SHALL, on sr/sl with shamt=k>=1, accept the shift: apply the first 1-bit shift on the accepting edge, latch smode and direction, and load remaining=k-1.
REQ-013 SHALL, on each following edge while remaining!=0, apply one more 1-bit shift and decrement remaining; busy = (remaining != 0).
REQ-014 SHALL raise done for exactly one cycle after the edge that applies the final shift; k=1 gives done with busy never high.
REQ-015 SHALL treat sr/sl with shamt=0 as a no-op: out, carry, done and busy unchanged.
REQ-016 SHALL, for right shift, fill the msb by mode: serial = ir, sampled each shift edge; rotate = old out[0]; arithmetic = old out[WIDTH-1].
REQ-017 SHALL, for left shift, fill the lsb by mode: serial = il, sampled each shift edge; rotate = old out[WIDTH-1]; arithmetic = 0.
REQ-018 SHALL set carry on every shift edge to the bit shifted out: out[0] for right, out[WIDTH-1] for left.
REQ-019 SHALL, while busy, ignore ld, inc, dec, sr, sl, smode and shamt; only cl and rst act.
REQ-020 SHALL accept a new shift on the edge where done is high: no dead cycle required.
REQ-021 SHALL drive zero combinationally from out, including during busy.

Reset
REQ-022 SHALL, on rst high at a rising clk edge, set out=0, carry=0, busy=0, done=0 and remaining=0, aborting any shift with no done pulse.
REQ-023 SHALL give rst priority over every command, including cl.

Verification
REQ-024 SHALL cover: WIDTH=8, SAT=0, ld 8'hFF then inc -> out=8'h00, carry=1, zero=1; then dec -> out=8'hFF, carry=1.
REQ-025 SHALL cover: SAT=1, ld 8'hFE, inc x3 -> out FF (carry 0), FF (carry 1), FF (carry 1); ld 8'h00, dec -> out=00, carry=1.
REQ-026 SHALL cover: ld 8'h81, sr, smode=01, shamt=3 -> out 8'hC0, 8'h60, 8'h30 on successive edges; busy high 2 cycles; done pulses once; carry ends 0.
REQ-027 SHALL cover: ld 8'h80, sr, smode=10, shamt=4 -> out=8'hF8; then sl, smode=00, il=1, shamt=1 -> out=8'hF1, carry=1, busy never high, done one cycle.
REQ-028 SHALL cover: shift with shamt=7 started, cl asserted on 3rd busy cycle -> out=0, busy=0 next cycle, no done; repeat with rst instead -> same result.
REQ-029 SHALL cover: inc and ld asserted during busy -> ignored, shift completes unchanged; new shift issued in done cycle -> accepted immediately.

Source files
------------

// File: rtl/univ_shift_counter.sv
// Universal register: clear, parallel load, up/down count (wrap or saturate) and
// multi-cycle 1-bit-per-edge shifting in serial, rotate or arithmetic mode.
module univ_shift_counter #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cl,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             sl,
    input  logic [WIDTH-1:0] in,
    input  logic             ir,
    input  logic             il,
    input  logic [1:0]       smode,
    input  logic [SW-1:0]    shamt,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_SERIAL     = 2'b00,
        MODE_ROTATE     = 2'b01,
        MODE_ARITH      = 2'b10,
        MODE_SERIAL_ALT = 2'b11
    } shift_mode_e;

    typedef struct packed {
        logic             bit_out;
        logic [WIDTH-1:0] value;
    } shift_res_t;

    logic [WIDTH-1:0] out_q,       out_d;
    logic             carry_q,     carry_d;
    logic [SW-1:0]    remaining_q, remaining_d;
    logic             right_q,     right_d;
    shift_mode_e      mode_q,      mode_d;
    logic             done_q,      done_d;

    logic             all_ones;
    logic             is_zero;
    logic             shifting;
    logic             accept;
    shift_mode_e      new_mode;
    shift_res_t       step_res;
    shift_res_t       start_res;

    // One 1-bit shift; serial fills use the ir/il value present on this edge.
    function automatic shift_res_t shift_one(
        input logic [WIDTH-1:0] v,
        input logic             right,
        input shift_mode_e      mode,
        input logic             ser_r,
        input logic             ser_l
    );
        shift_res_t r;
        logic       fill;
        fill = 1'b0;
        if (right) begin
            case (mode)
                MODE_ROTATE: fill = v[0];
                MODE_ARITH:  fill = v[WIDTH-1];
                default:     fill = ser_r;
            endcase
            r.value   = {fill, v[WIDTH-1:1]};
            r.bit_out = v[0];
        end else begin
            case (mode)
                MODE_ROTATE: fill = v[WIDTH-1];
                MODE_ARITH:  fill = 1'b0;
                default:     fill = ser_l;
            endcase
            r.value   = {v[WIDTH-2:0], fill};
            r.bit_out = v[WIDTH-1];
        end
        return r;
    endfunction

    assign all_ones = &out_q;
    assign is_zero  = (out_q == '0);
    assign shifting = (remaining_q != '0);
    assign accept   = (sr || sl) && (shamt != '0);
    assign new_mode = shift_mode_e'(smode);

    // In-flight shifts use the latched mode/direction; a new shift uses the live ones.
    assign step_res  = shift_one(out_q, right_q, mode_q, ir, il);
    assign start_res = shift_one(out_q, sr, new_mode, ir, il);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        out_d       = out_q;
        carry_d     = carry_q;
        remaining_d = remaining_q;
        right_d     = right_q;
        mode_d      = mode_q;
        done_d      = 1'b0;

        if (cl) begin
            out_d       = '0;
            carry_d     = 1'b0;
            remaining_d = '0;
        end else if (shifting) begin
            out_d       = step_res.value;
            carry_d     = step_res.bit_out;
            remaining_d = remaining_q - SW'(1);
            done_d      = (remaining_q == SW'(1));
        end else if (ld) begin
            out_d   = in;
            carry_d = 1'b0;
        end else if (inc) begin
            if (SAT != 0 && all_ones) begin
                carry_d = 1'b1;
            end else begin
                out_d   = out_q + WIDTH'(1);
                carry_d = all_ones;
            end
        end else if (dec) begin
            if (SAT != 0 && is_zero) begin
                carry_d = 1'b1;
            end else begin
                out_d   = out_q - WIDTH'(1);
                carry_d = is_zero;
            end
        end else if (accept) begin
            out_d       = start_res.value;
            carry_d     = start_res.bit_out;
            right_d     = sr;
            mode_d      = new_mode;
            remaining_d = shamt - SW'(1);
            done_d      = (shamt == SW'(1));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            carry_q     <= 1'b0;
            remaining_q <= '0;
            right_q     <= 1'b0;
            mode_q      <= MODE_SERIAL;
            done_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            carry_q     <= carry_d;
            remaining_q <= remaining_d;
            right_q     <= right_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = is_zero;
    assign busy  = shifting;
    assign done  = done_q;

endmodule
